// File: rtl/mdr_ctrl.sv
// Memory data register with req/ack memory handshake and byte/half/word load formatting.
// Optional macro MDR_TIMEOUT_EN adds a bounded wait for mem_ack with an err pulse on expiry.
module mdr_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [DATA_W-1:0]   bus_in,
    input  logic                enable_MDRin,
    input  logic                read,
    input  logic                write,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   output_Q,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int BE_W = DATA_W / 8;

    if (DATA_W < 16 || (DATA_W % 16) != 0 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("mdr_ctrl: DATA_W must be a multiple of 16 >= 16 and TIMEOUT in 1..255");
    end

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t     state;
    logic [1:0] size_q;
    logic       sign_q;

`ifdef MDR_TIMEOUT_EN
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] format_load(input logic [DATA_W-1:0] d,
                                                       input logic [1:0] sz,
                                                       input logic sx);
        logic [DATA_W-1:0] r;
        r = d;
        case (sz)
            2'b00: for (int i = 8; i < DATA_W; i++) r[i] = sx & d[7];
            2'b01: for (int i = 16; i < DATA_W; i++) r[i] = sx & d[15];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [BE_W-1:0] lane_enables(input logic [1:0] sz);
        logic [BE_W-1:0] b;
        b = '0;
        case (sz)
            2'b00: b[0] = 1'b1;
            2'b01: b[1:0] = 2'b11;
            default: b = '1;
        endcase
        return b;
    endfunction

    assign busy      = (state != IDLE);
    assign mem_wdata = output_Q;

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            output_Q <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_be   <= '0;
            done     <= 1'b0;
`ifdef MDR_TIMEOUT_EN
            wait_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MDR_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // read outranks write, which outranks a bus load; losers are dropped
                    if (read || write) begin
                        state    <= read ? RD : WR;
                        mem_req  <= 1'b1;
                        mem_we   <= ~read;
                        mem_be   <= lane_enables(size);
                        size_q   <= size;
                        sign_q   <= sign_ext;
`ifdef MDR_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else if (enable_MDRin) begin
                        output_Q <= bus_in;
                    end
                end
                RD, WR: begin
                    if (mem_ack) begin
                        if (state == RD)
                            output_Q <= format_load(mem_rdata, size_q, sign_q);
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
`ifdef MDR_TIMEOUT_EN
                    // an ack in the final allowed cycle is taken above before the abort
                    else if (wait_cnt == LAST_CNT) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        err_q   <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdr_ctrl.sv
// Scoreboard bench for mdr_ctrl: stimulus pushes expected done/err events, a monitor pops on each event.
module tb_mdr_ctrl;
    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] bus_in;
    logic        enable_MDRin, read, write, sign_ext, mem_ack;
    logic [1:0]  size;
    logic [31:0] mem_rdata;
    logic        mem_req, mem_we, busy, done, err;
    logic [31:0] mem_wdata, output_Q;
    logic [3:0]  mem_be;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_err;
        logic [31:0] q;
    } exp_t;
    exp_t sb[$];

    mdr_ctrl #(.DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .clr(clr), .bus_in(bus_in), .enable_MDRin(enable_MDRin),
        .read(read), .write(write), .size(size), .sign_ext(sign_ext),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .output_Q(output_Q), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit is_err, input logic [31:0] q);
        exp_t e;
        e.is_err = is_err;
        e.q      = q;
        sb.push_back(e);
    endtask

    // Monitor: every done/err pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (done || err) begin
            exp_t e;
            chk("done_err_exclusive", {31'd0, done & err}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_event", {31'd0, done}, {31'd0, 1'b0});
                chk("unexpected_err", {31'd0, err}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("event_is_err", {31'd0, err}, {31'd0, e.is_err});
                chk("event_output_Q", output_Q, e.q);
            end
        end
    end

    // Starts a command, acks in req cycle ack_cycle, reports how many cycles mem_req was high.
    task automatic run_xact(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                            input int ack_cycle, input logic [31:0] rdata,
                            input logic [3:0] exp_be, input logic exp_we,
                            input logic [31:0] exp_wdata, output int req_cycles);
        read = rd; write = wr; size = sz; sign_ext = sx;
        tick();
        read = 1'b0; write = 1'b0; enable_MDRin = 1'b0;
        req_cycles = 0;
        for (int i = 1; i <= ack_cycle; i++) begin
            if (mem_req) req_cycles++;
            if (i == 1) begin
                chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
                chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
                chk("mem_wdata", mem_wdata, exp_wdata);
                chk("busy_in_xact", {31'd0, busy}, 32'd1);
            end
            if (i == ack_cycle) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("mem_req_after_ack", {31'd0, mem_req}, 32'd0);
        chk("mem_be_after_ack", {28'd0, mem_be}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] q_now;
        clr = 1'b1; bus_in = '0; enable_MDRin = 1'b0; read = 1'b0; write = 1'b0;
        size = 2'b00; sign_ext = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        clr = 1'b0;

        // Reset after activity, including a read in flight
        enable_MDRin = 1'b1; bus_in = 32'h55AA55AA;
        tick();
        enable_MDRin = 1'b0; read = 1'b1;
        tick();
        read = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("rst_output_Q", output_Q, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // Bus load
        enable_MDRin = 1'b1; bus_in = 32'hDEADBEEF;
        tick();
        enable_MDRin = 1'b0;
        chk("load_output_Q", output_Q, 32'hDEADBEEF);
        chk("load_mem_req", {31'd0, mem_req}, 32'd0);
        chk("load_busy", {31'd0, busy}, 32'd0);
        chk("load_no_done", {31'd0, done}, 32'd0);

        // Byte reads, signed then unsigned, ack after 3 req cycles
        push_exp(1'b0, 32'hFFFFFF80);
        run_xact(1'b1, 1'b0, 2'b00, 1'b1, 3, 32'h12345680, 4'b0001, 1'b0, 32'hDEADBEEF, n);
        chk("rd_byte_sx_req_cycles", n, 3);
        push_exp(1'b0, 32'h00000080);
        run_xact(1'b1, 1'b0, 2'b00, 1'b0, 3, 32'h12345680, 4'b0001, 1'b0, 32'hFFFFFF80, n);
        chk("rd_byte_zx_req_cycles", n, 3);

        // Half signed read and word read, started in the done cycle
        push_exp(1'b0, 32'hFFFF8001);
        run_xact(1'b1, 1'b0, 2'b01, 1'b1, 1, 32'hABCD8001, 4'b0011, 1'b0, 32'h00000080, n);
        chk("rd_half_req_cycles", n, 1);
        push_exp(1'b0, 32'h87654321);
        run_xact(1'b1, 1'b0, 2'b11, 1'b1, 2, 32'h87654321, 4'b1111, 1'b0, 32'hFFFF8001, n);
        chk("rd_word_req_cycles", n, 2);

        // Half write, ack in first req cycle: output_Q untouched
        tick();
        enable_MDRin = 1'b1; bus_in = 32'hCAFEF00D;
        tick();
        enable_MDRin = 1'b0;
        push_exp(1'b0, 32'hCAFEF00D);
        run_xact(1'b0, 1'b1, 2'b01, 1'b0, 1, 32'h0BADBAD0, 4'b0011, 1'b1, 32'hCAFEF00D, n);
        chk("wr_req_cycles", n, 1);
        chk("wr_output_Q", output_Q, 32'hCAFEF00D);

        // read + write + enable together: read wins, bus load dropped
        enable_MDRin = 1'b1; bus_in = 32'h11111111;
        push_exp(1'b0, 32'hA5A5A5A5);
        run_xact(1'b1, 1'b1, 2'b10, 1'b0, 2, 32'hA5A5A5A5, 4'b1111, 1'b0, 32'hCAFEF00D, n);
        chk("prio_req_cycles", n, 2);
        tick();

`ifdef MDR_TIMEOUT_EN
        // No ack: abort after TIMEOUT req cycles with err
        push_exp(1'b1, 32'hA5A5A5A5);
        read = 1'b1; size = 2'b00; sign_ext = 1'b1;
        tick();
        read = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!mem_req) break;
            n++;
            tick();
        end
        chk("to_req_cycles", n, 4);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_output_Q", output_Q, 32'hA5A5A5A5);
        // Ack in the final cycle wins over the timeout
        push_exp(1'b0, 32'h0000007F);
        run_xact(1'b1, 1'b0, 2'b00, 1'b1, 4, 32'hFFFFFF7F, 4'b0001, 1'b0, 32'hA5A5A5A5, n);
        chk("to_ack_last_req_cycles", n, 4);
        q_now = 32'h0000007F;
`else
        // Without the timeout the request waits until clr
        read = 1'b1; size = 2'b00;
        tick();
        read = 1'b0;
        repeat (20) tick();
        chk("nto_busy", {31'd0, busy}, 32'd1);
        chk("nto_mem_req", {31'd0, mem_req}, 32'd1);
        chk("nto_err", {31'd0, err}, 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        q_now = 32'd0;
`endif
        tick();

        // Load ignored while busy, clr aborts, late ack in IDLE ignored
        read = 1'b1; size = 2'b10;
        tick();
        read = 1'b0; enable_MDRin = 1'b1; bus_in = 32'h00000001;
        tick();
        enable_MDRin = 1'b0;
        chk("busy_load_ignored", output_Q, q_now);
        chk("busy_mid_read", {31'd0, busy}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("abort_output_Q", output_Q, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_output_Q", output_Q, 32'd0);
        chk("late_ack_done", {31'd0, done}, 32'd0);
        chk("late_ack_busy", {31'd0, busy}, 32'd0);

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
